// File: rtl/door_pkg.sv
// Shared types and helpers for the door access controller family.
package door_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_CARD = 3'd1,
        DENIED    = 3'd2,
        LOCKOUT   = 3'd3,
        OPEN      = 3'd4,
        YIELD     = 3'd5
    } state_t;

    // Width needed to count 0..max_retries consecutive failures.
    function automatic int fail_w(input int max_retries);
        return $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Free-running blink generator. blink_phase presents the phase that will be held
// after the coming edge, so consumers can register it in step with their own state.
module blink_prescaler #(
    parameter int BLINK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    output logic blink_phase
);

    localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [DW-1:0] cnt_q;
    logic          phase_q;
    logic          wrap;

    assign wrap        = (cnt_q == DW'(BLINK_DIV - 1));
    assign blink_phase = phase_q ^ wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= wrap ? '0 : cnt_q + DW'(1);
            phase_q <= phase_q ^ wrap;
        end
    end

endmodule

// File: rtl/door_access_ctrl.sv
// Single-door access controller: card wait with timeout, retry limit with timed
// lockout, timed open window, yield to the opposite side, blinking red indicator.
module door_access_ctrl
    import door_pkg::*;
#(
    parameter int CARD_TIMEOUT   = 64,
    parameter int MAX_RETRIES    = 3,
    parameter int LOCKOUT_CYCLES = 1024,
    parameter int OPEN_CYCLES    = 256,
    parameter int BLINK_DIV      = 16,
    parameter int CNT_W          = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sensor_entrance,
    input  logic                            sensor_exit,
    input  logic                            card_present,
    input  logic                            card_valid,
    output logic                            GREEN_LED,
    output logic                            RED_LED,
    output logic                            door_status,
    output logic                            alarm,
    output logic [fail_w(MAX_RETRIES)-1:0] fail_count
);

    localparam int FW = fail_w(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [FW-1:0]    fail_d;
    logic             restart;
    logic             blink_nxt;
    logic             card_ok, card_bad;
    logic             green_d, red_d, door_d, alarm_d;

    blink_prescaler #(.BLINK_DIV(BLINK_DIV)) u_blink (
        .clk         (clk),
        .reset       (reset),
        .blink_phase (blink_nxt)
    );

    assign card_ok  = card_present & card_valid;
    assign card_bad = card_present & ~card_valid;

    always_comb begin
        state_d = state_q;
        fail_d  = fail_count;
        restart = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sensor_entrance | sensor_exit) state_d = WAIT_CARD;
            end
            WAIT_CARD, DENIED, YIELD: begin
                // A card strobe outranks a timeout landing on the same cycle.
                if (card_ok) begin
                    state_d = OPEN;
                    fail_d  = '0;
                end else if (card_bad) begin
                    fail_d  = fail_count + FW'(1);
                    state_d = (fail_d == FW'(MAX_RETRIES)) ? LOCKOUT : DENIED;
                    restart = 1'b1;
                end else if (timer_q == CNT_W'(CARD_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer_q == CNT_W'(LOCKOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            OPEN: begin
                if (timer_q == CNT_W'(OPEN_CYCLES - 1))
                    state_d = (sensor_entrance & sensor_exit) ? YIELD : IDLE;
            end
            default: state_d = IDLE;
        endcase
        timer_d = ((state_d != state_q) || restart) ? '0 : timer_q + CNT_W'(1);
    end

    // Outputs decode the upcoming state so they switch on the same edge as it.
    always_comb begin
        green_d = 1'b0;
        red_d   = 1'b0;
        door_d  = 1'b0;
        alarm_d = 1'b0;
        unique case (state_d)
            WAIT_CARD: red_d = 1'b1;
            DENIED:    red_d = blink_nxt;
            LOCKOUT: begin
                red_d   = blink_nxt;
                alarm_d = 1'b1;
            end
            OPEN: begin
                green_d = 1'b1;
                door_d  = 1'b1;
            end
            YIELD:     red_d = blink_nxt;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            fail_count  <= '0;
            GREEN_LED   <= 1'b0;
            RED_LED     <= 1'b0;
            door_status <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            fail_count  <= fail_d;
            GREEN_LED   <= green_d;
            RED_LED     <= red_d;
            door_status <= door_d;
            alarm       <= alarm_d;
        end
    end

endmodule

// File: tb/tb_door_access_ctrl.sv
// Bench for door_access_ctrl: a reference model of the access rules predicts the
// outputs each cycle; predictions are queued at drive time and compared after the edge.
module tb_door_access_ctrl;

    localparam int CARD_TIMEOUT   = 8;
    localparam int MAX_RETRIES    = 3;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int OPEN_CYCLES    = 5;
    localparam int BLINK_DIV      = 2;
    localparam int W              = 6;

    localparam int S_IDLE = 0, S_WAIT = 1, S_DEN = 2, S_LOCK = 3, S_OPEN = 4, S_YLD = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_entrance, sensor_exit, card_present, card_valid;
    logic       GREEN_LED, RED_LED, door_status, alarm;
    logic [1:0] fail_count;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int door_cnt, alarm_cnt;

    int m_state, m_timer, m_fail, m_cnt, m_phase;
    logic [W-1:0] m_out;

    door_access_ctrl #(
        .CARD_TIMEOUT  (CARD_TIMEOUT),
        .MAX_RETRIES   (MAX_RETRIES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .OPEN_CYCLES   (OPEN_CYCLES),
        .BLINK_DIV     (BLINK_DIV),
        .CNT_W         (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sensor_entrance(sensor_entrance),
        .sensor_exit    (sensor_exit),
        .card_present   (card_present),
        .card_valid     (card_valid),
        .GREEN_LED      (GREEN_LED),
        .RED_LED        (RED_LED),
        .door_status    (door_status),
        .alarm          (alarm),
        .fail_count     (fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic se, input logic sx,
                              input logic cp, input logic cv);
        int  ns, nf;
        bit  rs;
        bit  red;
        if (r) begin
            m_state = S_IDLE; m_timer = 0; m_fail = 0; m_cnt = 0; m_phase = 0;
            m_out = '0;
            return;
        end
        if (m_cnt == BLINK_DIV - 1) begin
            m_cnt = 0;
            m_phase = 1 - m_phase;
        end else begin
            m_cnt++;
        end
        ns = m_state; nf = m_fail; rs = 0;
        case (m_state)
            S_IDLE: if (se || sx) ns = S_WAIT;
            S_WAIT, S_DEN, S_YLD: begin
                if (cp && cv) begin
                    ns = S_OPEN; nf = 0;
                end else if (cp) begin
                    nf = m_fail + 1; rs = 1;
                    ns = (nf == MAX_RETRIES) ? S_LOCK : S_DEN;
                end else if (m_timer == CARD_TIMEOUT - 1) begin
                    ns = S_IDLE;
                end
            end
            S_LOCK: if (m_timer == LOCKOUT_CYCLES - 1) begin ns = S_IDLE; nf = 0; end
            S_OPEN: if (m_timer == OPEN_CYCLES - 1) ns = (se && sx) ? S_YLD : S_IDLE;
            default: ns = S_IDLE;
        endcase
        m_timer = (ns != m_state || rs) ? 0 : m_timer + 1;
        m_state = ns;
        m_fail  = nf;
        red = (ns == S_WAIT) || ((ns == S_DEN || ns == S_LOCK || ns == S_YLD) && m_phase == 1);
        m_out = {ns == S_OPEN, red, ns == S_OPEN, ns == S_LOCK, 2'(nf)};
    endtask

    // One clock of stimulus: predict, queue, clock, compare.
    task automatic step(input logic r, input logic se, input logic sx,
                        input logic cp, input logic cv);
        logic [W-1:0] got;
        reset = r; sensor_entrance = se; sensor_exit = sx;
        card_present = cp; card_valid = cv;
        model_step(r, se, sx, cp, cv);
        exp_q.push_back(m_out);
        @(posedge clk);
        #1;
        got = {GREEN_LED, RED_LED, door_status, alarm, fail_count};
        if (exp_q.size() == 0) check("queue_empty", 16'd1, 16'd0);
        else check("outs{g,r,d,a,f}", 16'(got), 16'(exp_q.pop_front()));
        if (door_status) door_cnt++;
        if (alarm) alarm_cnt++;
    endtask

    task automatic idle_n(input int n, input logic se, input logic sx);
        for (int i = 0; i < n; i++) step(1'b0, se, sx, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; sensor_entrance = 0; sensor_exit = 0; card_present = 0; card_valid = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("reset_outs", 16'({GREEN_LED, RED_LED, door_status, alarm, fail_count}), 16'd0);

        // 1: entrance, valid card 3 cycles later, exactly 5 open cycles
        door_cnt = 0;
        step(0, 1, 0, 0, 0);
        idle_n(2, 0, 0);
        step(0, 0, 0, 1, 1);
        idle_n(8, 0, 0);
        check("open_cycles", 16'(door_cnt), 16'd5);

        // 2: exit sensor, no card -> timeout
        step(0, 0, 1, 0, 0);
        idle_n(9, 0, 0);
        check("timeout_fail", 16'(fail_count), 16'd0);

        // 3: three invalid cards -> lockout, cards ignored during lockout
        alarm_cnt = 0;
        step(0, 1, 0, 0, 0);
        idle_n(2, 0, 0);
        step(0, 0, 0, 1, 0);
        idle_n(4, 0, 0);
        step(0, 0, 0, 1, 0);
        idle_n(3, 0, 0);
        step(0, 0, 0, 1, 0);
        check("fail_at_lock", 16'(fail_count), 16'd3);
        for (int i = 0; i < LOCKOUT_CYCLES + 2; i++)
            step(0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("alarm_cycles", 16'(alarm_cnt), 16'd16);
        check("fail_after_lock", 16'(fail_count), 16'd0);

        // 4: two invalid then valid
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        check("grant_clears_fail", 16'(fail_count), 16'd0);
        idle_n(6, 0, 0);

        // 5: both sensors held through a grant -> YIELD, card -> OPEN, then no card
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1);
        idle_n(5, 1, 1);
        check("yield_door", 16'(door_status), 16'd0);
        idle_n(2, 1, 1);
        step(0, 1, 1, 1, 1);
        idle_n(5, 1, 1);
        idle_n(10, 0, 0);

        // 6a: reset on 3rd OPEN cycle
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        idle_n(2, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_state", 16'(dut.state_q), 16'd0);
        check("rst_timer", 16'(dut.timer_q), 16'd0);

        // 6b: card on the timeout cycle wins
        step(0, 1, 0, 0, 0);
        idle_n(CARD_TIMEOUT - 1, 0, 0);
        step(0, 0, 0, 1, 1);
        check("card_beats_timeout", 16'(door_status), 16'd1);
        idle_n(6, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 2) == 0));

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
